// File: rtl/clk_div_bank.sv
// clk_div_bank: CH-channel programmable clock-enable divider with shadowed period/high-time config.
// Optional macro CLKDIV_SYNC_EN adds a Sync strobe that re-phases every enabled channel.
module clk_div_bank #(
  parameter int CH    = 4,
  parameter int WIDTH = 16,
  localparam int SEL_W = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [CH-1:0]    Enable,
  input  logic             CfgValid,
  output logic             CfgReady,
  input  logic [SEL_W-1:0] CfgSel,
  input  logic [WIDTH-1:0] CfgPeriod,
  input  logic [WIDTH-1:0] CfgHigh,
  output logic             CfgErr,
  output logic [CH-1:0]    ClkOut,
  output logic [CH-1:0]    Tick
`ifdef CLKDIV_SYNC_EN
  ,
  input  logic             Sync
`endif
);

  logic [CH-1:0] sel_hit;
  logic [CH-1:0] pend_vec;
  logic          sel_ok;
  logic          cfg_write;
  logic          cfg_accept;
  logic          err_d, err_q;
  logic          sync_now;

`ifdef CLKDIV_SYNC_EN
  assign sync_now = Sync;
`else
  assign sync_now = 1'b0;
`endif

  // An out-of-range select hits no channel, so it reads as ready and gets rejected.
  assign sel_ok     = |sel_hit;
  assign CfgReady   = ~|(sel_hit & pend_vec);
  assign cfg_write  = CfgValid & CfgReady;
  assign cfg_accept = cfg_write & sel_ok & (CfgPeriod >= WIDTH'(2));

  always_comb begin
    err_d = cfg_write & ~cfg_accept;
  end

  always_ff @(posedge Clk) begin
    if (Reset) err_q <= 1'b0;
    else       err_q <= err_d;
  end

  assign CfgErr = err_q;

  genvar gi;
  generate
    for (gi = 0; gi < CH; gi++) begin : g_ch
      localparam logic [SEL_W:0] IDX = (SEL_W+1)'(gi);

      logic [WIDTH-1:0] per_d, per_q, high_d, high_q;
      logic [WIDTH-1:0] sper_d, sper_q, shigh_d, shigh_q;
      logic [WIDTH-1:0] cnt_d, cnt_q;
      logic             pend_d, pend_q, run_d, run_q;
      logic             out_d, out_q, tick_d, tick_q;
      logic             apply;

      assign sel_hit[gi]  = ({1'b0, CfgSel} == IDX);
      assign pend_vec[gi] = pend_q;

      always_comb begin
        per_d   = per_q;
        high_d  = high_q;
        sper_d  = sper_q;
        shigh_d = shigh_q;
        pend_d  = pend_q;
        run_d   = run_q;
        cnt_d   = cnt_q;
        tick_d  = 1'b0;
        out_d   = 1'b0;
        apply   = 1'b0;
        if (!Enable[gi]) begin
          run_d = 1'b0;
          cnt_d = '0;
          apply = pend_q;
        end else if (sync_now) begin
          run_d  = 1'b1;
          cnt_d  = '0;
          tick_d = 1'b1;
          apply  = pend_q;
        end else if (!run_q) begin
          run_d  = 1'b1;
          cnt_d  = '0;
          tick_d = 1'b1;
        end else if (cnt_q >= per_q - WIDTH'(1)) begin
          cnt_d  = '0;
          tick_d = 1'b1;
          apply  = pend_q;
        end else begin
          cnt_d = cnt_q + WIDTH'(1);
        end
        // A write is only accepted while pend_q is clear, so it never collides with apply.
        if (apply) begin
          per_d  = sper_q;
          high_d = shigh_q;
          pend_d = 1'b0;
        end
        if (cfg_accept && sel_hit[gi]) begin
          sper_d  = CfgPeriod;
          shigh_d = CfgHigh;
          pend_d  = 1'b1;
        end
        if (Enable[gi]) out_d = (cnt_d < high_d);
      end

      always_ff @(posedge Clk) begin
        if (Reset) begin
          per_q   <= WIDTH'(2);
          high_q  <= WIDTH'(1);
          sper_q  <= WIDTH'(2);
          shigh_q <= WIDTH'(1);
          pend_q  <= 1'b0;
          run_q   <= 1'b0;
          cnt_q   <= '0;
          out_q   <= 1'b0;
          tick_q  <= 1'b0;
        end else begin
          per_q   <= per_d;
          high_q  <= high_d;
          sper_q  <= sper_d;
          shigh_q <= shigh_d;
          pend_q  <= pend_d;
          run_q   <= run_d;
          cnt_q   <= cnt_d;
          out_q   <= out_d;
          tick_q  <= tick_d;
        end
      end

      assign ClkOut[gi] = out_q;
      assign Tick[gi]   = tick_q;
    end
  endgenerate

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Multi-channel programmable clock-enable divider. It produces CH independent divided waveforms from the single system clock, each with its own period, high time and enable. It succeeds the single-channel divider with these changes:
- all logic works on the posedge only;
- duty cycle is programmable;
- configuration goes through a valid/ready handshake;
- new settings are applied glitch-free at period boundaries.

It sits between the control register file and the peripheral timing logic of the calculator datapath.

## Interface
- CH, 4, number of divider channels (1..16)
- WIDTH, 16, width of the period, high-time and counter fields (2..32)
- Clk  in  1  system clock; all logic on posedge
- Reset  in  1  reset, synchronous, active-high
- Enable  in  CH  per-channel run enable
- CfgValid  in  1  configuration write request
- CfgReady  out  1  configuration write can be accepted; combinational, equals ~pending[CfgSel]
- CfgSel  in  max(1,$clog2(CH))  target channel; values ≥ CH are illegal
- CfgPeriod  in  WIDTH  period P in Clk cycles
- CfgHigh  in  WIDTH  high time H in Clk cycles
- CfgErr  out  1  one-cycle pulse when a write is rejected
- ClkOut  out  CH  divided waveforms, registered
- Tick  out  CH  one-cycle pulse on the first cycle of each output period, registered
- Sync  in  1  phase-alignment strobe; present only with CLKDIV_SYNC_EN

## Operation
- Per-channel state:
  - active P and H registers;
  - shadow P and H registers with a pending flag;
  - counter cnt[WIDTH-1:0];
  - running flag.
- Reset values:
  - P=2, H=1 (divide-by-2, 50% duty);
  - cnt=0, running=0, pending=0;
  - ClkOut=0, Tick=0, CfgErr=0.
- Write handshake: a write occurs when CfgValid & CfgReady at a posedge.
  - If CfgPeriod<2 or CfgSel≥CH, the write is rejected: CfgErr pulses the next cycle and no state changes. The handshake still completes.
  - Otherwise the shadow registers load and pending is set.
- Enable[i]=0:
  - cnt←0, running←0, ClkOut[i]←0, Tick[i]←0;
  - a pending shadow is copied to active and pending is cleared.
- First enabled edge (running=0):
  - running←1, cnt←0;
  - ClkOut[i]←(H>0), Tick[i]←1.
- Running:
  - If cnt==P-1: cnt←0, Tick←1, and any pending shadow is copied to active (the wrap edge evaluates ClkOut with the new H).
  - Otherwise cnt←cnt+1, Tick←0.
  - ClkOut[i]←(cnt_next < H_active_next).
- Duty-cycle boundaries:
  - H=0 gives constant low while running; Tick still pulses.
  - H≥P gives constant high while running.
- Counters compare unsigned. cnt never exceeds P-1.
- A write landing on the same edge as that channel's wrap does not affect the current wrap. It is applied at the following wrap.

## Timing
- Enable rising: Enable sampled 1 at edge k gives ClkOut=(H>0) and Tick=1 after edge k.
- Enable falling: Enable sampled 0 at edge k gives ClkOut=0 after edge k. The falling edge aborts the current period.
- Output period is exactly P cycles. ClkOut is high for min(H,P) cycles, starting at the Tick cycle.
- Config latency: a write accepted at edge k on a running channel takes effect at its next wrap edge. The earliest is edge k+1 if cnt==P-1 at that edge.
- CfgReady for a channel returns high on the cycle after its pending value is applied.
- Reset asserted mid-period: all channels return to reset values at that edge, and pending writes are discarded.
- Reset has priority over Sync, Enable and writes.

## Configuration
- CLKDIV_SYNC_EN defined:
  - The Sync input exists.
  - Sync=1 at an edge makes every channel with Enable=1 do the following: cnt←0, Tick←1, pending applied, ClkOut←(H>0).
  - Sync overrides the normal increment on that edge.
- CLKDIV_SYNC_EN undefined: the Sync port and its logic are absent. Channels align only via Enable.

## Test plan
- Default divide-by-2: release Reset, set Enable=0001 → ClkOut[0] toggles 1,0,1,0… starting the cycle after Enable; Tick[0] pulses every 2 cycles.
- Programmed duty: write ch1 P=5, H=2, then enable ch1 → ClkOut[1]=1,1,0,0,0 repeating; Tick[1] on every 5th cycle.
- Duty-cycle boundaries: ch2 with H=0, P=3 → ClkOut[2] stays 0 and Tick pulses every 3 cycles; with H=7, P=3 → ClkOut[2] stays 1.
- Handshake:
  - running ch0 with P=4, H=2; write P=6, H=3 mid-period → the old pattern completes, then 6-cycle periods start at the wrap;
  - a second write before that wrap sees CfgReady=0.
- Rejection: write CfgPeriod=1, or CfgSel=CH → CfgErr=1 for one cycle, CfgReady stays 1, the outputs are unchanged.
- Reset and Sync:
  - Reset pulsed during a period → all ClkOut=0 and P/H read back as 2/1;
  - with CLKDIV_SYNC_EN, channels with P=3 and P=5 are re-phased by Sync → both Tick=1 on the same cycle after Sync.
